// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if : handshake/data bundle between the EX stage and the divider.
//
// Signals
//   start_i    EX stage holds a DIV/DIVU (held stable while ok_o is low)
//   signed_i   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i  32-bit dividend
//   opdata2_i  32-bit divisor
//   annul_i    flush request, cancels any operation in progress
//   ok_o       0 = divider busy, stall the pipeline; 1 = EX may advance
//   ready_o    result_o is valid this cycle
//   result_o   {hi = remainder, lo = quotient}
//
// Modports
//   master : pipeline side (drives the request, observes the status)
//   slave  : divider side
// ---------------------------------------------------------------------------
interface div_if;
   logic        start_i;
   logic        signed_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        annul_i;
   logic        ok_o;
   logic        ready_o;
   logic [63:0] result_o;

   modport master (
      output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      input  ok_o, ready_o, result_o
   );

   modport slave (
      input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      output ok_o, ready_o, result_o
   );
endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit : multi-cycle 32-bit radix-2 restoring divider for the EX stage.
//
// Divides operand magnitudes one bit per cycle, then applies the sign fix-up
// (quotient negated when the operand signs differ, remainder takes the sign
// of the dividend) for DIV; DIVU uses the raw operands. Divide by zero yields
// {dividend, 32'hFFFFFFFF}. ok_o is combinational so the pipeline stalls in
// the very cycle a divide is first presented.
//
// Ports
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : div_if.slave (start_i, signed_i, opdata1_i, opdata2_i, annul_i,
//          ok_o, ready_o, result_o)
//
// Build option
//   DIV_BYPASS_EN : when defined, a zero divisor or zero dividend skips the
//                   iterative phase and goes straight from IDLE to DONE.
// ---------------------------------------------------------------------------
module div_unit (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [31:0] quo_reg;       // dividend bits shift out of the top, quotient bits in at the bottom
   logic [31:0] rem_reg;       // partial remainder
   logic [31:0] divisor_reg;   // |divisor|
   logic [31:0] dividend_raw;  // unmodified dividend for the divide-by-zero result
   logic        qsign;
   logic        rsign;
   logic        dz;
   logic [63:0] result_reg;
   logic        ready_reg;

   // Operand magnitudes as seen in IDLE
   logic        op1_neg;
   logic        op2_neg;
   logic [31:0] abs1;
   logic [31:0] abs2;

   assign op1_neg = bus.signed_i & bus.opdata1_i[31];
   assign op2_neg = bus.signed_i & bus.opdata2_i[31];
   assign abs1    = op1_neg ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
   assign abs2    = op2_neg ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;

   // One restoring step. The trial value needs 33 bits because the partial
   // remainder can be as large as divisor-1 before the shift.
   logic [32:0] trial;
   logic [32:0] diff;
   logic        no_borrow;
   logic [31:0] rem_step;
   logic [31:0] quo_step;

   assign trial     = {rem_reg, quo_reg[31]};
   assign diff      = trial - {1'b0, divisor_reg};
   assign no_borrow = ~diff[32];
   assign rem_step  = no_borrow ? diff[31:0] : trial[31:0];
   assign quo_step  = {quo_reg[30:0], no_borrow};

   // Sign fix-up applied to the values produced by the final step
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [63:0] final_result;

   assign quo_fix      = qsign ? (32'd0 - quo_step) : quo_step;
   assign rem_fix      = rsign ? (32'd0 - rem_step) : rem_step;
   assign final_result = dz ? {dividend_raw, 32'hFFFF_FFFF} : {rem_fix, quo_fix};

`ifdef DIV_BYPASS_EN
   logic        bypass_hit;
   logic [63:0] bypass_result;

   assign bypass_hit    = (bus.opdata2_i == 32'd0) | (bus.opdata1_i == 32'd0);
   // Zero divisor takes priority: 0/0 still reports {dividend, all ones}
   assign bypass_result = (bus.opdata2_i == 32'd0) ? {bus.opdata1_i, 32'hFFFF_FFFF} : 64'd0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 5'd0;
         quo_reg      <= 32'd0;
         rem_reg      <= 32'd0;
         divisor_reg  <= 32'd0;
         dividend_raw <= 32'd0;
         qsign        <= 1'b0;
         rsign        <= 1'b0;
         dz           <= 1'b0;
         result_reg   <= 64'd0;
         ready_reg    <= 1'b0;
      end else begin
         ready_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i && !bus.annul_i) begin
                  quo_reg      <= abs1;
                  rem_reg      <= 32'd0;
                  divisor_reg  <= abs2;
                  dividend_raw <= bus.opdata1_i;
                  qsign        <= op1_neg ^ op2_neg;
                  rsign        <= op1_neg;
                  dz           <= (bus.opdata2_i == 32'd0);
                  cnt          <= 5'd0;
`ifdef DIV_BYPASS_EN
                  if (bypass_hit) begin
                     result_reg <= bypass_result;
                     ready_reg  <= 1'b1;
                     state      <= DONE;
                  end else begin
                     state <= BUSY;
                  end
`else
                  state <= BUSY;
`endif
               end
            end
            BUSY: begin
               if (bus.annul_i) begin
                  state <= IDLE;
               end else begin
                  rem_reg <= rem_step;
                  quo_reg <= quo_step;
                  cnt     <= cnt + 5'd1;
                  if (cnt == 5'd31) begin
                     result_reg <= final_result;
                     ready_reg  <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            // Always fall back to IDLE so a still-asserted start_i is not
            // mistaken for a fresh request of the same instruction.
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ok_o     = ~(((state == IDLE) & bus.start_i & ~bus.annul_i) |
                           ((state == BUSY) & ~bus.annul_i));
   // A flush arriving in the DONE cycle suppresses the completion pulse
   assign bus.ready_o  = ready_reg & ~bus.annul_i;
   assign bus.result_o = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit : self-checking bench for div_unit. Expected results come from
// an arithmetic reference model (64-bit integer division); expected timing
// comes from the documented cycle counts.
// ---------------------------------------------------------------------------
module tb_div_unit;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   div_if bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: {remainder, quotient}
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] qv;
      logic [63:0] rv;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (!s) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;            // truncates toward zero
      r  = sa - q * sb;
      qv = 64'(q);
      rv = 64'(r);
      return {rv[31:0], qv[31:0]};
   endfunction

   // Expected index (cycles after the start cycle) of the DONE cycle
   function automatic int exp_done(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_BYPASS_EN
      if (a == 32'd0 || b == 32'd0) return 1;
`endif
      return 33;
   endfunction

   task automatic idle_inputs();
      bus.start_i   = 1'b0;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = 32'd0;
      bus.opdata2_i = 32'd0;
      bus.annul_i   = 1'b0;
   endtask

   // Runs one divide and checks result, stall length, done cycle and pulse count
   task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic scramble);
      logic [63:0] res;
      logic [63:0] expv;
      int ok_low;
      int done_c;
      int extra;
      expv   = model(a, b, s);
      res    = 64'd0;
      ok_low = 0;
      done_c = -1;
      extra  = 0;
      @(posedge clk); #1;
      bus.start_i   = 1'b1;
      bus.signed_i  = s;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      for (int c = 0; c < 60 && done_c < 0; c++) begin
         @(negedge clk);
         if (!bus.ok_o) ok_low++;
         if (bus.ready_o) begin
            done_c = c;
            res    = bus.result_o;
         end else if (scramble && c == 1) begin
            #2;
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom;
         end
      end
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.ready_o) extra++;
      end
      checks += 4;
      if (done_c !== exp_done(a, b)) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d expected %0d", name, done_c, exp_done(a, b));
      end
      if (res !== expv) begin
         errors++;
         $display("FAIL %s result: got %h expected %h", name, res, expv);
      end
      if (ok_low !== exp_done(a, b)) begin
         errors++;
         $display("FAIL %s ok_low_cycles: got %0d expected %0d", name, ok_low, exp_done(a, b));
      end
      if (extra !== 0) begin
         errors++;
         $display("FAIL %s extra_ready: got %0d expected 0", name, extra);
      end
      $display("div %s a=%h b=%h s=%0d result=%h ok_low=%0d", name, a, b, s, res, ok_low);
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks += 3;
      if (bus.ok_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ok: got %b expected 1", bus.ok_o);
      end
      if (bus.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
      end
      if (bus.result_o !== 64'd0) begin
         errors++;
         $display("FAIL reset_result: got %h expected 0", bus.result_o);
      end
      $display("reset ok=%b ready=%b result=%h", bus.ok_o, bus.ready_o, bus.result_o);
   endtask

   task automatic test_directed();
      run_one("divu_100_7",   32'd100,        32'd7,          1'b0, 1'b0);
      run_one("div_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0);
      run_one("div_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0);
      run_one("div_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0);
      run_one("divu_max_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0);
      run_one("divu_5_0",     32'd5,          32'd0,          1'b0, 1'b0);
      run_one("div_m5_0",     32'hFFFF_FFFB,  32'd0,          1'b1, 1'b0);
      run_one("div_0_9",      32'd0,          32'd9,          1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         b = (i % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
         if (i % 5 == 1) b = $urandom_range(1, 16);
         s = 1'($urandom_range(0, 1));
         run_one("random", a, b, s, 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] r1;
      logic [63:0] r2;
      int c1;
      int c2;
      c1 = -1;
      c2 = -1;
      r1 = 64'd0;
      r2 = 64'd0;
      @(posedge clk); #1;
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b1;
      bus.opdata1_i = 32'hFFFF_FC18;  // -1000
      bus.opdata2_i = 32'd33;
      for (int c = 0; c < 120 && c2 < 0; c++) begin
         @(negedge clk);
         if (bus.ready_o) begin
            if (c1 < 0) begin
               c1 = c;
               r1 = bus.result_o;
               @(posedge clk); #1;
               bus.opdata1_i = 32'd123456789;
               bus.opdata2_i = 32'hFFFF_FF85;  // -123
               c++;
               @(negedge clk);
               if (bus.ready_o) c2 = c;  // a pulse here would be wrong
            end else begin
               c2 = c;
               r2 = bus.result_o;
            end
         end
      end
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      checks += 3;
      if (r1 !== model(32'hFFFF_FC18, 32'd33, 1'b1)) begin
         errors++;
         $display("FAIL b2b_first: got %h expected %h", r1, model(32'hFFFF_FC18, 32'd33, 1'b1));
      end
      if (r2 !== model(32'd123456789, 32'hFFFF_FF85, 1'b1)) begin
         errors++;
         $display("FAIL b2b_second: got %h expected %h", r2, model(32'd123456789, 32'hFFFF_FF85, 1'b1));
      end
      if (c2 - c1 !== 34) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d expected 34", c2 - c1);
      end
      $display("b2b r1=%h r2=%h spacing=%0d", r1, r2, c2 - c1);
      repeat (2) @(posedge clk);
   endtask

   task automatic test_annul();
      int nready;
      logic ok_same;
      logic ok_next;
      nready = 0;
      @(posedge clk); #1;
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = 32'd1000;
      bus.opdata2_i = 32'd3;
      repeat (10) @(negedge clk);      // cycles 0..9
      @(posedge clk); #1;              // BUSY cycle 10
      bus.annul_i = 1'b1;
      @(negedge clk);
      ok_same = bus.ok_o;
      @(posedge clk); #1;
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      @(negedge clk);
      ok_next = bus.ok_o;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.ready_o) nready++;
      end
      checks += 3;
      if (ok_same !== 1'b1) begin
         errors++;
         $display("FAIL annul_ok_same_cycle: got %b expected 1", ok_same);
      end
      if (ok_next !== 1'b1) begin
         errors++;
         $display("FAIL annul_ok_next_cycle: got %b expected 1", ok_next);
      end
      if (nready !== 0) begin
         errors++;
         $display("FAIL annul_ready: got %0d pulses expected 0", nready);
      end
      $display("annul ok_same=%b ok_next=%b ready_pulses=%0d", ok_same, ok_next, nready);
   endtask

   task automatic test_reset_mid();
      int nready;
      logic ok_r;
      logic rdy_r;
      logic [63:0] res_r;
      nready = 0;
      @(posedge clk); #1;
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b1;
      bus.opdata1_i = 32'h7654_3210;
      bus.opdata2_i = 32'd17;
      repeat (5) @(negedge clk);      // cycles 0..4
      @(posedge clk); #2;             // mid BUSY cycle 5, away from the edge
      rst         = 1'b1;
      bus.start_i = 1'b0;
      #1;
      ok_r  = bus.ok_o;
      rdy_r = bus.ready_o;
      res_r = bus.result_o;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.ready_o) nready++;
      end
      checks += 4;
      if (ok_r !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_ok: got %b expected 1", ok_r);
      end
      if (rdy_r !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ready: got %b expected 0", rdy_r);
      end
      if (res_r !== 64'd0) begin
         errors++;
         $display("FAIL rstmid_result: got %h expected 0", res_r);
      end
      if (nready !== 0) begin
         errors++;
         $display("FAIL rstmid_no_output: got %0d pulses expected 0", nready);
      end
      $display("rst_mid ok=%b ready=%b result=%h later_pulses=%0d", ok_r, rdy_r, res_r, nready);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_annul();
      test_reset_mid();
      run_one("after_rst", 32'd100, 32'd7, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute guard so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
